vga_frame_buffer: RTL and testbench

- Parametrised, double-buffered image frame buffer for the VGA display path. Successor to the fixed 128x128, scale-by-4, fixed-offset image buffer.
- The CPU bus side streams pixels into the back bank through an auto-incrementing write pointer. The VGA side reads the front bank at a programmable origin and power-of-two scale.
- Pixels outside the image window return a programmable background colour.
- Bank swap is requested by software and takes effect only at frame start, which removes tearing.

---
 rtl/vga_frame_buffer.sv | 123 ++++++++++++
 tb/tb_vga_frame_buffer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vga_frame_buffer.sv
// Double-buffered image frame buffer: the CPU streams pixels into the back bank,
// and the VGA side reads the front bank at a programmable origin and scale.
module vga_frame_buffer #(
  parameter int DATA_W     = 8,
  parameter int IMG_W_LOG2 = 7,
  parameter int IMG_H_LOG2 = 7,
  parameter int DOUBLE_BUF = 1,
  localparam int ADDR_W    = IMG_W_LOG2 + IMG_H_LOG2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              frame_start,
  input  logic [9:0]        cfg_org_x,
  input  logic [9:0]        cfg_org_y,
  input  logic [1:0]        cfg_scale,
  input  logic [DATA_W-1:0] bg_color,
  input  logic              wr_addr_set,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic              front_sel,
  output logic [DATA_W-1:0] image_rgb
);

  localparam int BANK_W = (DOUBLE_BUF != 0) ? 1 : 0;
  localparam int RAM_AW = ADDR_W + BANK_W;
  localparam int DEPTH  = 1 << RAM_AW;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              front_sel_q, front_sel_d;
  logic              swap_pending_q, swap_pending_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [RAM_AW-1:0] raddr_q, raddr_d;
  logic              win_d1_q, win_d1_d;
  logic              win_d2_q, win_d2_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic [10:0]           dx, dy;
  logic [11:0]           lim_x, lim_y;
  logic [IMG_W_LOG2-1:0] img_x;
  logic [IMG_H_LOG2-1:0] img_y;
  logic [ADDR_W-1:0]     wr_target;
  logic [RAM_AW-1:0]     waddr;
  logic                  swap_fire;

  // Window test in 11 bits so a pixel left of/above the origin can never wrap in.
  always_comb begin
    dx    = {1'b0, pixel_x} - {1'b0, cfg_org_x};
    dy    = {1'b0, pixel_y} - {1'b0, cfg_org_y};
    lim_x = (12'd1 << IMG_W_LOG2) << cfg_scale;
    lim_y = (12'd1 << IMG_H_LOG2) << cfg_scale;
    img_x = IMG_W_LOG2'(dx >> cfg_scale);
    img_y = IMG_H_LOG2'(dy >> cfg_scale);
    win_d1_d = (pixel_x >= cfg_org_x) && ({1'b0, dx} < lim_x) &&
               (pixel_y >= cfg_org_y) && ({1'b0, dy} < lim_y);
    win_d2_d = win_d1_q;
  end

  generate
    if (DOUBLE_BUF != 0) begin : g_dbl
      assign raddr_d = {front_sel_q, img_y, img_x};
      assign waddr   = {~front_sel_q, wr_target};
    end else begin : g_sgl
      assign raddr_d = {img_y, img_x};
      assign waddr   = wr_target;
    end
  endgenerate

  assign rd_data_d = mem[raddr_q];

  always_comb begin
    swap_fire      = (DOUBLE_BUF != 0) && frame_start && (swap_pending_q || swap_req);
    swap_pending_d = (DOUBLE_BUF != 0) && (swap_pending_q || swap_req) && !swap_fire;
    front_sel_d    = front_sel_q ^ swap_fire;
  end

  // Pointer priority: explicit load beats the swap-time rewind, which beats a plain increment.
  always_comb begin
    wr_target = wr_addr_set ? wr_addr : wr_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    if (wr_valid)
      wr_ptr_d = wr_target + 1'b1;
    else if (wr_addr_set)
      wr_ptr_d = wr_addr;
    if (swap_fire && !wr_addr_set)
      wr_ptr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (wr_valid)
      mem[waddr] <= wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      wr_ptr_q       <= '0;
      raddr_q        <= '0;
      win_d1_q       <= 1'b0;
      win_d2_q       <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      front_sel_q    <= front_sel_d;
      swap_pending_q <= swap_pending_d;
      wr_ptr_q       <= wr_ptr_d;
      raddr_q        <= raddr_d;
      win_d1_q       <= win_d1_d;
      win_d2_q       <= win_d2_d;
      rd_data_q      <= rd_data_d;
    end
  end

  assign front_sel    = front_sel_q;
  assign swap_pending = swap_pending_q;
  assign image_rgb    = win_d2_q ? rd_data_q : bg_color;

endmodule

// File: tb/tb_vga_frame_buffer.sv
// Directed bench for vga_frame_buffer: writes, swaps, window/scale reads and reset.
module tb_vga_frame_buffer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [9:0]  pixel_x, pixel_y, cfg_org_x, cfg_org_y;
  logic        frame_start;
  logic [1:0]  cfg_scale;
  logic [7:0]  bg_color;
  logic        wr_addr_set;
  logic [13:0] wr_addr;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        swap_req;
  logic        swap_pending, front_sel;
  logic [7:0]  image_rgb;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_frame_buffer dut (
    .clk(clk), .resetn(resetn), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start), .cfg_org_x(cfg_org_x), .cfg_org_y(cfg_org_y),
    .cfg_scale(cfg_scale), .bg_color(bg_color), .wr_addr_set(wr_addr_set),
    .wr_addr(wr_addr), .wr_valid(wr_valid), .wr_data(wr_data), .swap_req(swap_req),
    .swap_pending(swap_pending), .front_sel(front_sel), .image_rgb(image_rgb)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("[%0t] %s observed=%0h expected=%0h ok", $time, tag, obs, exp);
    end else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick(1);
    wr_valid = 1'b0;
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [7:0] exp);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    tick(2);
    check(tag, {24'd0, image_rgb}, {24'd0, exp});
  endtask

  initial begin
    resetn = 1'b0; pixel_x = '0; pixel_y = '0; frame_start = 1'b0;
    cfg_org_x = '0; cfg_org_y = '0; cfg_scale = '0; bg_color = 8'h03;
    wr_addr_set = 1'b0; wr_addr = '0; wr_valid = 1'b0; wr_data = '0; swap_req = 1'b0;

    // 1: reset state
    tick(2);
    check("rst_rgb", {24'd0, image_rgb}, 32'h03);
    check("rst_front", {31'd0, front_sel}, 32'd0);
    check("rst_pending", {31'd0, swap_pending}, 32'd0);
    pix("rst_sweep0", 0, 0, 8'h03);
    pix("rst_sweep1", 100, 50, 8'h03);
    resetn = 1'b1;
    tick(1);

    // 2: write AA, BB into back bank 1, swap, read at scale 0
    wr_addr_set = 1'b1; wr_addr = 14'd0;
    tick(1);
    wr_addr_set = 1'b0;
    wr(8'hAA);
    wr(8'hBB);
    swap_req = 1'b1;
    tick(1);
    swap_req = 1'b0;
    check("pend_set", {31'd0, swap_pending}, 32'd1);
    check("pend_front0", {31'd0, front_sel}, 32'd0);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    check("swap1_front", {31'd0, front_sel}, 32'd1);
    check("swap1_pend", {31'd0, swap_pending}, 32'd0);
    cfg_org_x = 10'd64; cfg_org_y = 10'd0;
    pix("s0_64_0", 64, 0, 8'hAA);
    pix("s0_65_0", 65, 0, 8'hBB);
    pix("s0_63_0", 63, 0, 8'h03);

    // 3: scale 2
    cfg_scale = 2'd2;
    pix("s2_67_3", 67, 3, 8'hAA);
    pix("s2_68_0", 68, 0, 8'hBB);
    pix("s2_576_0", 576, 0, 8'h03);
    cfg_org_x = 10'd600;
    pix("s2_nowrap", 5, 0, 8'h03);
    bg_color = 8'h5A;
    #1;
    check("bg_comb", {24'd0, image_rgb}, 32'h5A);
    bg_color = 8'h03;

    // 4: pointer load with write at top address, wrap, then swap back to bank 0
    wr_addr_set = 1'b1; wr_addr = 14'd16383; wr_valid = 1'b1; wr_data = 8'h11;
    tick(1);
    wr_addr_set = 1'b0; wr_valid = 1'b0;
    wr(8'h22);
    wr(8'h33);
    swap_req = 1'b1; frame_start = 1'b1;
    tick(1);
    swap_req = 1'b0; frame_start = 1'b0;
    check("swap2_front", {31'd0, front_sel}, 32'd0);
    cfg_org_x = 10'd0; cfg_org_y = 10'd0; cfg_scale = 2'd0;
    pix("b0_top", 127, 127, 8'h11);
    pix("b0_wrap0", 0, 0, 8'h22);
    pix("b0_ptr1", 1, 0, 8'h33);
    pix("edge_x128", 128, 0, 8'h03);
    pix("edge_y128", 0, 128, 8'h03);

    // 5: repeated requests, hidden write until swap
    wr(8'h44);
    swap_req = 1'b1;
    tick(1);
    swap_req = 1'b0;
    tick(1);
    swap_req = 1'b1;
    tick(1);
    swap_req = 1'b0;
    check("dbl_pend", {31'd0, swap_pending}, 32'd1);
    check("dbl_front", {31'd0, front_sel}, 32'd0);
    pix("hidden", 0, 0, 8'h22);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    check("dbl_swap_front", {31'd0, front_sel}, 32'd1);
    check("dbl_swap_pend", {31'd0, swap_pending}, 32'd0);
    pix("visible", 0, 0, 8'h44);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    check("idle_fs_front", {31'd0, front_sel}, 32'd1);

    // 6: reset with swap pending
    swap_req = 1'b1;
    tick(1);
    swap_req = 1'b0;
    check("pre_rst_pend", {31'd0, swap_pending}, 32'd1);
    resetn = 1'b0;
    #1;
    check("arst_front", {31'd0, front_sel}, 32'd0);
    check("arst_pend", {31'd0, swap_pending}, 32'd0);
    check("arst_rgb", {24'd0, image_rgb}, 32'h03);
    #1;
    resetn = 1'b1;
    tick(1);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    check("post_rst_front", {31'd0, front_sel}, 32'd0);
    check("post_rst_pend", {31'd0, swap_pending}, 32'd0);
    pix("ram_kept", 0, 0, 8'h22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
